// File: rtl/scroll_lanes.sv
// Multi-lane horizontal obstacle scroller: one wrapped x position per lane,
// all advanced together on a shared movement tick that speeds up with score.
module scroll_lanes #(
  parameter int LANES        = 4,
  parameter int POS_W        = 10,
  parameter int SCREEN_WIDTH = 640,
  parameter int TICK         = 50000,
  parameter int CTR_W        = 18,
  parameter int STEP         = 2,
  parameter int SCORE_SHIFT  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   pause,
  input  logic [7:0]             score,
  input  logic [LANES*POS_W-1:0] start_posx,
  input  logic [LANES-1:0]       lane_dir,
  input  logic [2*LANES-1:0]     lane_speed,
  output logic [LANES*POS_W-1:0] h_pos,
  output logic                   tick,
  output logic [LANES-1:0]       wrap
);

  localparam int PW = POS_W + 1;
  localparam int SW = 8 + SCORE_SHIFT;
  localparam int MW = (SW > CTR_W) ? SW : CTR_W;
  localparam logic [PW-1:0]    SCR      = PW'(SCREEN_WIDTH);
  localparam logic [MW-1:0]    TICK_M1  = MW'(TICK - 1);
  localparam logic [CTR_W-1:0] TICK_CTR = CTR_W'(TICK);

  logic [CTR_W-1:0]       r_ctr;
  logic [LANES*POS_W-1:0] r_pos;
  logic                   r_tick;
  logic [LANES-1:0]       r_wrap;

  logic [MW-1:0]          w_shifted;
  logic [CTR_W-1:0]       w_preload;
  logic                   w_event;
  logic [LANES*POS_W-1:0] w_clampPos;
  logic [LANES*POS_W-1:0] w_movePos;
  logic [LANES-1:0]       w_moveWrap;
  logic [PW-1:0]          w_start;
  logic [PW-1:0]          w_p;
  logic [PW-1:0]          w_s;
  logic [PW-1:0]          w_sum;

  // Shift is done wide enough that a large score saturates instead of aliasing.
  assign w_shifted = MW'(score) << SCORE_SHIFT;
  assign w_preload = (w_shifted > TICK_M1) ? CTR_W'(TICK_M1) : CTR_W'(w_shifted);
  assign w_event   = (r_ctr >= TICK_CTR);

  always_comb begin
    w_clampPos = '0;
    w_movePos  = '0;
    w_moveWrap = '0;
    w_start    = '0;
    w_p        = '0;
    w_s        = '0;
    w_sum      = '0;
    for (int i = 0; i < LANES; i++) begin
      w_start = {1'b0, start_posx[i*POS_W +: POS_W]};
      w_clampPos[i*POS_W +: POS_W] = (w_start < SCR) ? w_start[POS_W-1:0] : '0;

      w_p = {1'b0, r_pos[i*POS_W +: POS_W]};
      w_s = PW'(lane_speed[2*i +: 2]) * PW'(STEP);
      w_sum = w_p;
      if (w_s != '0) begin
        if (lane_dir[i]) begin
          w_sum = w_p + w_s;
          if (w_sum >= SCR) begin
            w_sum = w_sum - SCR;
            w_moveWrap[i] = 1'b1;
          end
        end else if (w_p < w_s) begin
          w_sum = w_p + SCR - w_s;
          w_moveWrap[i] = 1'b1;
        end else begin
          w_sum = w_p - w_s;
        end
      end
      w_movePos[i*POS_W +: POS_W] = w_sum[POS_W-1:0];
    end
  end

  // Load beats pause, pause beats the move event; tick/wrap are single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos  <= w_clampPos;
      r_ctr  <= '0;
      r_tick <= 1'b0;
      r_wrap <= '0;
    end else if (load) begin
      r_pos  <= w_clampPos;
      r_ctr  <= '0;
      r_tick <= 1'b0;
      r_wrap <= '0;
    end else if (pause) begin
      r_tick <= 1'b0;
      r_wrap <= '0;
    end else if (w_event) begin
      r_ctr  <= w_preload;
      r_tick <= 1'b1;
      r_pos  <= w_movePos;
      r_wrap <= w_moveWrap;
    end else begin
      r_ctr  <= r_ctr + 1'b1;
      r_tick <= 1'b0;
      r_wrap <= '0;
    end
  end

  assign h_pos = r_pos;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_scroll_lanes.sv
// Directed self-checking bench for scroll_lanes with a short tick period.
module tb_scroll_lanes;

  localparam int LANES = 4;
  localparam int POS_W = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   load;
  logic                   pause;
  logic [7:0]             score;
  logic [LANES*POS_W-1:0] start_posx;
  logic [LANES-1:0]       lane_dir;
  logic [2*LANES-1:0]     lane_speed;
  logic [LANES*POS_W-1:0] h_pos;
  logic                   tick;
  logic [LANES-1:0]       wrap;

  int errors = 0;
  int checks = 0;

  scroll_lanes #(
    .LANES(4), .POS_W(10), .SCREEN_WIDTH(640), .TICK(9),
    .CTR_W(18), .STEP(2), .SCORE_SHIFT(0)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .pause(pause), .score(score),
    .start_posx(start_posx), .lane_dir(lane_dir), .lane_speed(lane_speed),
    .h_pos(h_pos), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Counts rising edges until tick is seen; -1 means it never came.
  task automatic waitTick(output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (tick) found = 1'b1;
    end
    if (!found) cycles = -1;
  endtask

  task automatic doReset(input logic [LANES*POS_W-1:0] st, input logic [3:0] dir,
                         input logic [7:0] spd);
    start_posx = st;
    lane_dir   = dir;
    lane_speed = spd;
    load       = 1'b0;
    pause      = 1'b0;
    score      = 8'd0;
    reset      = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    int c;
    start_posx = {10'd600, 10'd300, 10'd100, 10'd0};
    lane_dir = 4'b1111; lane_speed = 8'b01010101;
    load = 1'b0; pause = 1'b0; score = 8'd0;
    reset = 1'b0;
    #12;
    checks++;
    if (h_pos !== {10'd600, 10'd300, 10'd100, 10'd0}) begin
      errors++; $display("[TB] FAIL reset_pos got=%h want=%h", h_pos, {10'd600, 10'd300, 10'd100, 10'd0});
    end
    checks++;
    if (tick !== 1'b0 || wrap !== 4'b0) begin
      errors++; $display("[TB] FAIL reset_pulses tick=%b wrap=%b want 0/0", tick, wrap);
    end
    @(negedge clk);
    reset = 1'b1;
    waitTick(c);
    checks++;
    if (c !== 10) begin errors++; $display("[TB] FAIL first_tick_latency got=%0d want=10", c); end
    checks++;
    if (h_pos !== {10'd602, 10'd302, 10'd102, 10'd2}) begin
      errors++; $display("[TB] FAIL first_move got=%h want=%h", h_pos, {10'd602, 10'd302, 10'd102, 10'd2});
    end
    checks++;
    if (wrap !== 4'b0) begin errors++; $display("[TB] FAIL first_wrap got=%b want=0000", wrap); end
    @(posedge clk); #1;
    checks++;
    if (tick !== 1'b0) begin errors++; $display("[TB] FAIL tick_one_cycle got=%b want=0", tick); end
  endtask

  task automatic test_right_wrap;
    int c;
    doReset({10'd10, 10'd10, 10'd10, 10'd638}, 4'b1111, 8'b01010111);
    waitTick(c);
    checks++;
    if (c !== 10 || h_pos !== {10'd12, 10'd12, 10'd12, 10'd4}) begin
      errors++; $display("[TB] FAIL right_wrap_pos got=%h cyc=%0d want=%h cyc=10", h_pos, c, {10'd12, 10'd12, 10'd12, 10'd4});
    end
    checks++;
    if (wrap !== 4'b0001) begin errors++; $display("[TB] FAIL right_wrap_flag got=%b want=0001", wrap); end
    @(posedge clk); #1;
    checks++;
    if (wrap !== 4'b0000) begin errors++; $display("[TB] FAIL right_wrap_pulse got=%b want=0000", wrap); end
  endtask

  task automatic test_left_wrap_stationary;
    int c;
    int exp1, exp3, exp0;
    doReset({10'd400, 10'd50, 10'd1, 10'd20}, 4'b0001, 8'b10000101);
    waitTick(c);
    checks++;
    if (h_pos !== {10'd396, 10'd50, 10'd639, 10'd22} || wrap !== 4'b0010) begin
      errors++; $display("[TB] FAIL left_wrap got=%h wrap=%b want=%h wrap=0010", h_pos, wrap, {10'd396, 10'd50, 10'd639, 10'd22});
    end
    for (int t = 2; t <= 5; t++) begin
      waitTick(c);
      checks++;
      if (c !== 10 || h_pos[29:20] !== 10'd50 || wrap !== 4'b0000) begin
        errors++; $display("[TB] FAIL stationary_lane t=%0d lane2=%0d wrap=%b cyc=%0d want 50/0000/10", t, h_pos[29:20], wrap, c);
      end
    end
    exp0 = 30; exp1 = 631; exp3 = 380;
    checks++;
    if (h_pos !== {10'(exp3), 10'd50, 10'(exp1), 10'(exp0)}) begin
      errors++; $display("[TB] FAIL five_ticks got=%h want=%h", h_pos, {10'(exp3), 10'd50, 10'(exp1), 10'(exp0)});
    end
  endtask

  task automatic test_score;
    int c;
    int want [5] = '{10, 6, 6, 2, 2};
    score = 8'd4;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) score = 8'd200;
      waitTick(c);
      checks++;
      if (c !== want[k]) begin errors++; $display("[TB] FAIL score_period k=%0d got=%0d want=%0d", k, c, want[k]); end
    end
    score = 8'd0;
  endtask

  task automatic test_pause_load;
    int c, cnt;
    logic [LANES*POS_W-1:0] saved;
    bit sawTick, moved;
    doReset({10'd600, 10'd300, 10'd100, 10'd0}, 4'b1111, 8'b01010101);
    waitTick(c);
    saved = h_pos;
    sawTick = 1'b0; moved = 1'b0; cnt = 0;
    repeat (3) begin @(posedge clk); #1; cnt++; end
    pause = 1'b1;
    repeat (20) begin
      @(posedge clk); #1; cnt++;
      if (tick) sawTick = 1'b1;
      if (h_pos !== saved) moved = 1'b1;
    end
    pause = 1'b0;
    checks++;
    if (sawTick || moved) begin errors++; $display("[TB] FAIL pause_freeze tick=%b moved=%b want 0/0", sawTick, moved); end
    waitTick(c);
    checks++;
    if (c < 0 || cnt + c !== 30) begin errors++; $display("[TB] FAIL pause_period got=%0d want=30", cnt + c); end
    checks++;
    if (h_pos !== {10'd604, 10'd304, 10'd104, 10'd4}) begin
      errors++; $display("[TB] FAIL pause_pos got=%h want=%h", h_pos, {10'd604, 10'd304, 10'd104, 10'd4});
    end
    repeat (9) @(posedge clk);
    #1;
    start_posx = {10'd5, 10'd6, 10'd7, 10'd700};
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    checks++;
    if (h_pos !== {10'd5, 10'd6, 10'd7, 10'd0} || tick !== 1'b0) begin
      errors++; $display("[TB] FAIL load_priority got=%h tick=%b want=%h tick=0", h_pos, tick, {10'd5, 10'd6, 10'd7, 10'd0});
    end
    waitTick(c);
    checks++;
    if (c !== 10 || h_pos !== {10'd7, 10'd8, 10'd9, 10'd2}) begin
      errors++; $display("[TB] FAIL load_next_tick cyc=%0d got=%h want cyc=10 %h", c, h_pos, {10'd7, 10'd8, 10'd9, 10'd2});
    end
  endtask

  task automatic test_async_reset;
    int c;
    repeat (3) @(posedge clk);
    start_posx = {10'd3, 10'd2, 10'd1, 10'd700};
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (h_pos !== {10'd3, 10'd2, 10'd1, 10'd0} || tick !== 1'b0 || wrap !== 4'b0) begin
      errors++; $display("[TB] FAIL async_reset got=%h tick=%b wrap=%b want=%h 0 0000", h_pos, tick, wrap, {10'd3, 10'd2, 10'd1, 10'd0});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    waitTick(c);
    checks++;
    if (c !== 10 || h_pos !== {10'd5, 10'd4, 10'd3, 10'd2}) begin
      errors++; $display("[TB] FAIL restart_after_reset cyc=%0d got=%h want cyc=10 %h", c, h_pos, {10'd5, 10'd4, 10'd3, 10'd2});
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; pause = 1'b0; score = 8'd0;
    start_posx = '0; lane_dir = '0; lane_speed = '0;
    test_reset();
    test_right_wrap();
    test_left_wrap_stationary();
    test_score();
    test_pause_load();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
